// File: rtl/mac_pkg.sv
// Shared constants and helpers for the pipelined dot-product MAC.
// Saturation limits are used only when MAC_DOT_SAT_EN is defined.
package mac_pkg;

    localparam int LIM_W = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int prod_w(input int aw, input int bw);
        return aw + bw;
    endfunction

    function automatic logic [LIM_W-1:0] sat_umax(input int w);
        return (LIM_W'(1) << w) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] sat_smax(input int w);
        return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] sat_smin(input int w);
        return ~sat_smax(w);
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered A_W x B_W multiplier stage with valid/last sideband.
// Operands are extended to the product width so one multiply covers both signednesses.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int A_W    = 4,
    parameter int B_W    = 4,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [A_W-1:0]                a,
    input  logic [B_W-1:0]                b,
    output logic                          valid,
    output logic                          last,
    output logic [prod_w(A_W, B_W)-1:0]   p
);

    localparam int PW = prod_w(A_W, B_W);

    logic [PW-1:0] ax;
    logic [PW-1:0] bx;

    assign ax = {{B_W{(SIGNED != 0) && a[A_W-1]}}, a};
    assign bx = {{A_W{(SIGNED != 0) && b[B_W-1]}}, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            last  <= 1'b0;
            p     <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= in_valid;
            last  <= in_last;
            p     <= ax * bx;
        end
    end

endmodule

// File: rtl/mac_dot_pipe.sv
// Pipelined multiply-accumulate dot-product engine with valid/ready handshakes.
// Define MAC_DOT_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_dot_pipe
    import mac_pkg::*;
#(
    parameter int A_W     = 4,
    parameter int B_W     = 4,
    parameter int ACC_W   = 10,
    parameter int DOT_LEN = 4,
    parameter int SIGNED  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] y,
    output logic             ovf
);

    localparam int PW = prod_w(A_W, B_W);
    localparam int CW = clog2(DOT_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(DOT_LEN - 1);

    logic             adv;
    logic             take;
    logic [CW-1:0]    cnt;
    logic [A_W-1:0]   s1_a;
    logic [B_W-1:0]   s1_b;
    logic             s1_v;
    logic             s1_last;
    logic             s2_v;
    logic             s2_last;
    logic [PW-1:0]    s2_p;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic             sticky;
    logic [ACC_W:0]   p_ext;
    logic [ACC_W:0]   a_ext;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !acc_clr;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else if (acc_clr) begin
            cnt  <= '0;
            s1_v <= 1'b0;
        end else if (adv) begin
            s1_v    <= take;
            s1_last <= (cnt == LAST_CNT);
            s1_a    <= a;
            s1_b    <= b;
            if (take) begin
                cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
            end
        end
    end

    mac_mult_stage #(
        .A_W    (A_W),
        .B_W    (B_W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .clr      (acc_clr),
        .in_valid (s1_v),
        .in_last  (s1_last),
        .a        (s1_a),
        .b        (s1_b),
        .valid    (s2_v),
        .last     (s2_last),
        .p        (s2_p)
    );

    // One guard bit above ACC_W exposes both unsigned carry-out and signed overflow.
    always_comb begin
        p_ext = {{(ACC_W + 1 - PW){(SIGNED != 0) && s2_p[PW-1]}}, s2_p};
        a_ext = {(SIGNED != 0) && acc[ACC_W-1], acc};
        sum   = a_ext + p_ext;
        if (SIGNED != 0) begin
            sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
        end else begin
            sum_ovf = sum[ACC_W];
        end
        acc_nxt = sum[ACC_W-1:0];
`ifdef MAC_DOT_SAT_EN
        if (sum_ovf) begin
            if (SIGNED == 0) begin
                acc_nxt = ACC_W'(sat_umax(ACC_W));
            end else if (sum[ACC_W]) begin
                acc_nxt = ACC_W'(sat_smin(ACC_W));
            end else begin
                acc_nxt = ACC_W'(sat_smax(ACC_W));
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sticky    <= 1'b0;
            y         <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc_clr) begin
                acc    <= '0;
                sticky <= 1'b0;
            end else if (adv && s2_v) begin
                if (s2_last) begin
                    y         <= acc_nxt;
                    out_valid <= 1'b1;
                    ovf       <= sticky || sum_ovf;
                    acc       <= '0;
                    sticky    <= 1'b0;
                end else begin
                    acc    <= acc_nxt;
                    sticky <= sticky || sum_ovf;
                end
            end
        end
    end

endmodule
